// File: rtl/acc_report_framer.sv
// acc_report_framer
// Snapshots the signed accumulator's status outputs and streams them as a
// fixed 15-byte frame (header, status, acc, min, max, cycle count, checksum)
// over a byte-wide valid/ready interface. Frames are sent periodically and
// immediately on a new overflow/underflow event.
module acc_report_framer #(
  parameter int REPORT_PERIOD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] acc,
  input  logic        overflow_flag,
  input  logic        underflow_flag,
  input  logic [15:0] min_val,
  input  logic [15:0] max_val,
  input  logic [31:0] cycle_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [7:0]  dropped_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [15:0] PERIOD_LAST = 16'(REPORT_PERIOD - 1);
  localparam logic [3:0]  LAST_IDX    = 4'd14;
  localparam logic [7:0]  HEADER      = 8'hA5;
  localparam logic [7:0]  DROP_MAX    = 8'hFF;

  // Shadow layout, most significant first, so frame byte k (1..13) is the
  // k-th byte counted from the top:
  //   [103:96] status, [95:64] acc, [63:48] min_val,
  //   [47:32] max_val, [31:0] cycle_count
  state_t        state_q, state_d;
  logic [15:0]   period_cnt_q, period_cnt_d;
  logic          ovf_prev_q, ovf_prev_d;
  logic          unf_prev_q, unf_prev_d;
  logic          pending_alarm_q, pending_alarm_d;
  logic [7:0]    dropped_q, dropped_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [103:0]  shadow_q, shadow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic          busy_q, busy_d;

  logic          periodic_trig;
  logic          alarm_trig;
  logic          accept;

  assign periodic_trig = (period_cnt_q == PERIOD_LAST);
  assign alarm_trig    = (overflow_flag & ~ovf_prev_q) | (underflow_flag & ~unf_prev_q);
  assign accept        = tx_valid_q & tx_ready;

  // Selects frame byte idx from a snapshot; index 14 (and anything above)
  // yields the running checksum.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [103:0] snap,
                                            input logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = snap[103:96];
      4'd2:    b = snap[95:88];
      4'd3:    b = snap[87:80];
      4'd4:    b = snap[79:72];
      4'd5:    b = snap[71:64];
      4'd6:    b = snap[63:56];
      4'd7:    b = snap[55:48];
      4'd8:    b = snap[47:40];
      4'd9:    b = snap[39:32];
      4'd10:   b = snap[31:24];
      4'd11:   b = snap[23:16];
      4'd12:   b = snap[15:8];
      4'd13:   b = snap[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

  // Next-state logic: period counter, edge detection, trigger arbitration and
  // the IDLE/SEND frame sequencer with its registered stream outputs.
  always_comb begin
    state_d         = state_q;
    period_cnt_d    = (period_cnt_q == PERIOD_LAST) ? 16'd0 : period_cnt_q + 16'd1;
    ovf_prev_d      = overflow_flag;
    unf_prev_d      = underflow_flag;
    pending_alarm_d = pending_alarm_q;
    dropped_d       = dropped_q;
    idx_d           = idx_q;
    chk_d           = chk_q;
    shadow_d        = shadow_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    tx_last_d       = tx_last_q;
    busy_d          = busy_q;

    case (state_q)
      IDLE: begin
        if (periodic_trig || alarm_trig || pending_alarm_q) begin
          shadow_d        = {6'b0, underflow_flag, overflow_flag,
                             acc, min_val, max_val, cycle_count};
          idx_d           = 4'd0;
          chk_d           = 8'd0;
          pending_alarm_d = 1'b0;
          state_d         = SEND;
          tx_data_d       = HEADER;
          tx_valid_d      = 1'b1;
          tx_last_d       = 1'b0;
          busy_d          = 1'b1;
        end
      end

      SEND: begin
        if (alarm_trig) begin
          pending_alarm_d = 1'b1;
        end else if (periodic_trig && (dropped_q != DROP_MAX)) begin
          dropped_d = dropped_q + 8'd1;
        end

        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d    = IDLE;
            idx_d      = 4'd0;
            tx_data_d  = 8'd0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            busy_d     = 1'b0;
          end else begin
            idx_d     = idx_q + 4'd1;
            chk_d     = (idx_q == 4'd0) ? chk_q : (chk_q ^ tx_data_q);
            tx_data_d = frame_byte(idx_d, shadow_q, chk_d);
            tx_last_d = (idx_d == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-frame
  // simply abandons the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      period_cnt_q    <= 16'd0;
      ovf_prev_q      <= 1'b0;
      unf_prev_q      <= 1'b0;
      pending_alarm_q <= 1'b0;
      dropped_q       <= 8'd0;
      idx_q           <= 4'd0;
      chk_q           <= 8'd0;
      shadow_q        <= 104'd0;
      tx_data_q       <= 8'd0;
      tx_valid_q      <= 1'b0;
      tx_last_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      ovf_prev_q      <= ovf_prev_d;
      unf_prev_q      <= unf_prev_d;
      pending_alarm_q <= pending_alarm_d;
      dropped_q       <= dropped_d;
      idx_q           <= idx_d;
      chk_q           <= chk_d;
      shadow_q        <= shadow_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      tx_last_q       <= tx_last_d;
      busy_q          <= busy_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign tx_last       = tx_last_q;
  assign busy          = busy_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_acc_report_framer.sv
// tb_acc_report_framer
// Drives the framer with directed scenarios followed by randomized traffic and
// compares every cycle against a frame-level behavioural model.
module tb_acc_report_framer;

  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] acc;
  logic        overflow_flag;
  logic        underflow_flag;
  logic [15:0] min_val;
  logic [15:0] max_val;
  logic [31:0] cycle_count;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic [7:0]  dropped_count;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  acc_report_framer #(.REPORT_PERIOD(PERIOD)) dut (
    .clk           (clk),
    .reset         (reset),
    .acc           (acc),
    .overflow_flag (overflow_flag),
    .underflow_flag(underflow_flag),
    .min_val       (min_val),
    .max_val       (max_val),
    .cycle_count   (cycle_count),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_last       (tx_last),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  int check_count = 0;
  int error_count = 0;

  // Values to present on the next applyStimulus call.
  logic        n_reset = 1'b1;
  logic        n_ready = 1'b1;
  logic        n_ovf   = 1'b0;
  logic        n_unf   = 1'b0;
  logic [31:0] n_acc   = 32'd0;
  logic [15:0] n_min   = 16'd0;
  logic [15:0] n_max   = 16'd0;
  logic [31:0] n_cc    = 32'd0;

  // Reference model state, describing the outputs visible in the current cycle.
  bit         m_busy    = 1'b0;
  int         m_pos     = 0;
  logic [7:0] m_frame[15];
  bit         m_pending = 1'b0;
  int         m_dropped = 0;
  int         m_cnt     = 0;
  bit         m_prev_ovf = 1'b0;
  bit         m_prev_unf = 1'b0;
  bit         m_rst     = 1'b1;
  int         m_frames  = 0;

  // Observation bookkeeping.
  logic [7:0] obs_q[$];
  int         tb_cycle = 0;
  bit         prev_obs_valid = 1'b0;
  bit         arm_gap = 1'b0;
  int         first_last = -1;
  int         first_hdr = -1;
  int         edges_since_rst = 0;
  int         hdr_edges = -1;

  logic [7:0] golden[15] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF,
                             8'hFB, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h10,
                             8'h78};

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
               tag, observed, expected, tb_cycle);
    end
  endtask

  // Builds the complete frame the spec describes from the sampled inputs.
  task automatic model_capture();
    logic [7:0] chk;
    m_frame[0]  = 8'hA5;
    m_frame[1]  = {6'b0, n_unf, n_ovf};
    m_frame[2]  = n_acc[31:24];
    m_frame[3]  = n_acc[23:16];
    m_frame[4]  = n_acc[15:8];
    m_frame[5]  = n_acc[7:0];
    m_frame[6]  = n_min[15:8];
    m_frame[7]  = n_min[7:0];
    m_frame[8]  = n_max[15:8];
    m_frame[9]  = n_max[7:0];
    m_frame[10] = n_cc[31:24];
    m_frame[11] = n_cc[23:16];
    m_frame[12] = n_cc[15:8];
    m_frame[13] = n_cc[7:0];
    chk = 8'd0;
    for (int i = 1; i <= 13; i++) chk ^= m_frame[i];
    m_frame[14] = chk;
  endtask

  // Advances the model by one clock edge using the inputs just applied.
  task automatic model_step();
    bit periodic;
    bit alarm;
    if (n_reset) begin
      m_busy = 0; m_pos = 0; m_pending = 0; m_dropped = 0; m_cnt = 0;
      m_prev_ovf = 0; m_prev_unf = 0; m_rst = 1;
    end else begin
      m_rst    = 0;
      periodic = ((m_cnt % PERIOD) == PERIOD - 1);
      m_cnt++;
      alarm = (n_ovf && !m_prev_ovf) || (n_unf && !m_prev_unf);
      if (!m_busy) begin
        if (periodic || alarm || m_pending) begin
          model_capture();
          m_pos = 0; m_busy = 1; m_pending = 0; m_frames++;
        end
      end else begin
        if (alarm) m_pending = 1;
        else if (periodic && m_dropped < 255) m_dropped++;
        if (n_ready) begin
          if (m_pos == 14) m_busy = 0;
          else m_pos++;
        end
      end
      m_prev_ovf = n_ovf;
      m_prev_unf = n_unf;
    end
  endtask

  // One cycle: check outputs against the model, then apply the next inputs.
  task automatic applyStimulus();
    @(negedge clk);
    tb_cycle++;
    checkOutput("tx_valid", tx_valid, m_busy);
    checkOutput("busy", busy, m_busy);
    checkOutput("tx_last", tx_last, (m_busy && m_pos == 14));
    checkOutput("dropped_count", dropped_count, m_dropped);
    if (m_busy || m_rst)
      checkOutput("tx_data", tx_data, m_busy ? m_frame[m_pos] : 8'd0);

    if (tx_valid === 1'b1 && !prev_obs_valid) begin
      if (hdr_edges < 0) hdr_edges = edges_since_rst;
      if (arm_gap && first_hdr < 0 && first_last >= 0) first_hdr = tb_cycle;
    end
    if (tx_valid === 1'b1 && tx_last === 1'b1 && arm_gap && first_last < 0)
      first_last = tb_cycle;
    prev_obs_valid = (tx_valid === 1'b1);

    reset          = n_reset;
    tx_ready       = n_ready;
    overflow_flag  = n_ovf;
    underflow_flag = n_unf;
    acc            = n_acc;
    min_val        = n_min;
    max_val        = n_max;
    cycle_count    = n_cc;
    if (tx_valid === 1'b1 && n_ready) obs_q.push_back(tx_data);
    if (n_reset) begin
      edges_since_rst = 0;
      hdr_edges = -1;
    end else begin
      edges_since_rst++;
    end
    model_step();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Waits (bounded) until the model presents byte pos of a frame.
  task automatic wait_for_pos(input int pos, input bit periodic_start, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_busy && m_pos == pos && (!periodic_start || (m_cnt % PERIOD) == 0))
        found = 1'b1;
      else
        applyStimulus();
    end
    checkOutput(tag, found, 1);
  endtask

  task automatic wait_for_idle(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!m_busy) found = 1'b1;
      else applyStimulus();
    end
    checkOutput(tag, found, 1);
  endtask

  initial begin
    int f0;
    int n_frames;

    reset = 1'b1; tx_ready = 1'b1; overflow_flag = 1'b0; underflow_flag = 1'b0;
    acc = 32'd0; min_val = 16'd0; max_val = 16'd0; cycle_count = 32'd0;

    // Reset state and the first periodic frame.
    n_acc = 32'h12345678; n_min = 16'hFFFB; n_max = 16'd100; n_cc = 32'h10;
    run_cycles(3);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_last", tx_last, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_dropped", dropped_count, 0);
    obs_q.delete();
    n_reset = 1'b0;
    run_cycles(40);
    checkOutput("first_hdr_edges", hdr_edges, 16);
    checkOutput("first_frame_len", obs_q.size() >= 15, 1);
    for (int i = 0; i < 15 && i < obs_q.size(); i++)
      checkOutput($sformatf("first_frame_byte%0d", i), obs_q[i], golden[i]);

    // Backpressure: ready pattern 1,0,0.
    wait_for_idle("bp_wait_idle");
    obs_q.delete();
    for (int i = 0; i < 90; i++) begin
      n_ready = (i % 3 == 0);
      applyStimulus();
    end
    n_ready = 1'b1;
    checkOutput("bp_frame_len", obs_q.size() >= 15, 1);
    for (int i = 0; i < 15 && i < obs_q.size(); i++)
      checkOutput($sformatf("bp_frame_byte%0d", i), obs_q[i], golden[i]);

    // Overflow rising while byte 5 is presented.
    wait_for_pos(5, 1'b0, "alarm_wait_pos5");
    arm_gap = 1'b1; first_last = -1; first_hdr = -1;
    n_ovf = 1'b1;
    applyStimulus();
    obs_q.delete();
    run_cycles(40);
    checkOutput("alarm_gap", first_hdr - first_last, 2);
    checkOutput("alarm_len", obs_q.size() >= 11, 1);
    if (obs_q.size() >= 11) begin
      for (int i = 0; i < 9; i++)
        checkOutput($sformatf("alarm_cur_byte%0d", i + 6), obs_q[i], golden[i + 6]);
      checkOutput("alarm_next_hdr", obs_q[9], 8'hA5);
      checkOutput("alarm_next_status", obs_q[10], 8'h01);
    end
    arm_gap = 1'b0;
    n_ovf = 1'b0;

    // Reset asserted while byte 7 is presented.
    wait_for_pos(7, 1'b0, "rst_wait_pos7");
    n_reset = 1'b1;
    applyStimulus();
    n_reset = 1'b0;
    applyStimulus();
    checkOutput("rst_mid_tx_valid", tx_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_dropped", dropped_count, 0);
    run_cycles(30);
    checkOutput("rst_hdr_edges", hdr_edges, 16);

    // Dropped periodic triggers under a long stall.
    wait_for_pos(0, 1'b1, "drop_wait_hdr");
    n_ready = 1'b0;
    run_cycles(40);
    checkOutput("drop_after_40", dropped_count, 2);
    run_cycles(16);
    checkOutput("drop_after_56", dropped_count, 3);
    run_cycles(255 * PERIOD);
    checkOutput("drop_saturated", dropped_count, 255);
    n_ready = 1'b1;
    wait_for_idle("drop_wait_idle");

    // Underflow held high for 100 cycles.
    obs_q.delete();
    f0 = m_frames;
    n_unf = 1'b1;
    run_cycles(100);
    n_unf = 1'b0;
    wait_for_idle("held_wait_idle");
    n_frames = m_frames - f0;
    checkOutput("held_bytes", obs_q.size(), 15 * n_frames);
    checkOutput("held_frames_min", n_frames >= 6, 1);
    if (obs_q.size() >= 2) checkOutput("held_alarm_status", obs_q[1], 8'h02);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      n_acc   = $urandom;
      n_min   = 16'($urandom);
      n_max   = 16'($urandom);
      n_cc    = $urandom;
      n_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) n_ovf = ~n_ovf;
      if ($urandom_range(0, 39) == 0) n_unf = ~n_unf;
      n_reset = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end
    n_reset = 1'b0;
    n_ready = 1'b1;
    run_cycles(20);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
